// File: rtl/hall_sensor_conditioner_pkg.sv
// hall_pkg: shared widths, hall code constants and sector helpers for the hall conditioner
// Contents:
//   HALL_W / SECTOR_W    widths of the {H3,H2,H1} code and of the sector number
//   CODE_S0..CODE_S5     legal hall codes in forward rotation order
//   SECTOR_NONE          decode result for the illegal codes 000 and 111
//   hall_decode          {H3,H2,H1} -> sector 0..5 or SECTOR_NONE
//   hall_encode          sector 0..5 -> {H3,H2,H1}
//   sector_fwd           next sector in the forward direction (mod 6)
package hall_pkg;
  localparam int HALL_W = 3;
  localparam int SECTOR_W = 3;
  localparam logic [SECTOR_W-1:0] SECTOR_NONE = 3'd7;
  localparam logic [HALL_W-1:0] CODE_S0 = 3'b001;
  localparam logic [HALL_W-1:0] CODE_S1 = 3'b101;
  localparam logic [HALL_W-1:0] CODE_S2 = 3'b100;
  localparam logic [HALL_W-1:0] CODE_S3 = 3'b110;
  localparam logic [HALL_W-1:0] CODE_S4 = 3'b010;
  localparam logic [HALL_W-1:0] CODE_S5 = 3'b011;

  function automatic logic [SECTOR_W-1:0] hall_decode(input logic [HALL_W-1:0] code);
    case (code)
      CODE_S0: return 3'd0;
      CODE_S1: return 3'd1;
      CODE_S2: return 3'd2;
      CODE_S3: return 3'd3;
      CODE_S4: return 3'd4;
      CODE_S5: return 3'd5;
      default: return SECTOR_NONE;
    endcase
  endfunction

  function automatic logic [HALL_W-1:0] hall_encode(input logic [SECTOR_W-1:0] sector);
    case (sector)
      3'd0: return CODE_S0;
      3'd1: return CODE_S1;
      3'd2: return CODE_S2;
      3'd3: return CODE_S3;
      3'd4: return CODE_S4;
      3'd5: return CODE_S5;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [SECTOR_W-1:0] sector_fwd(input logic [SECTOR_W-1:0] sector);
    return (sector == 3'd5) ? 3'd0 : sector + 3'd1;
  endfunction
endpackage

// File: rtl/hall_sensor_conditioner_if.sv
// hall_sensor_conditioner_if: raw hall inputs and conditioned hall/status outputs
// Signals:
//   h1_in/h2_in/h3_in   raw asynchronous hall inputs
//   h1/h2/h3            debounced hall code
//   sector              decoded sector 0..5 (holds last legal value)
//   sector_ok           a legal code has been accepted since reset
//   edge_pulse          1-cycle pulse on each accepted code change
//   dir                 1 = forward, 0 = reverse
//   skip                1-cycle pulse on a legal jump of 2 or 3 sectors
//   hall_err            accepted code is 000 or 111
//   period/period_valid cycles between the last two adjacent-sector edges
//   stall               no accepted edge for the stall timeout
// Modports: master drives the raw inputs, slave is the conditioner.
interface hall_sensor_conditioner_if import hall_pkg::*; #(
  parameter int PER_W = 20
);
  logic h1_in, h2_in, h3_in;
  logic h1, h2, h3;
  logic [SECTOR_W-1:0] sector;
  logic sector_ok, edge_pulse, dir, skip, hall_err;
  logic [PER_W-1:0] period;
  logic period_valid, stall;

  modport master (
    output h1_in, h2_in, h3_in,
    input h1, h2, h3, sector, sector_ok, edge_pulse, dir, skip, hall_err, period, period_valid, stall
  );

  modport slave (
    input h1_in, h2_in, h3_in,
    output h1, h2, h3, sector, sector_ok, edge_pulse, dir, skip, hall_err, period, period_valid, stall
  );
endinterface

// File: rtl/hall_sensor_conditioner_debounce.sv
// hall_debounce: 2-FF synchroniser and shared-counter filter for the 3-bit hall code
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   raw        asynchronous {H3,H2,H1}
//   code       accepted (debounced) code, registered
//   cand       synchronised sample that is being qualified
//   accept     combinational strobe: cand becomes code on this clock edge
module hall_debounce import hall_pkg::*; #(
  parameter int DEB_CYCLES = 8,
  parameter int DEB_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [HALL_W-1:0] raw,
  output logic [HALL_W-1:0] code,
  output logic [HALL_W-1:0] cand,
  output logic accept
);
  logic [HALL_W-1:0] s1, s2, prev;
  logic [DEB_W-1:0] cnt, nxt;

  // cnt holds the number of consecutive identical samples of a code that differs from code;
  // a change of sample restarts the run at one.
  always_comb begin
    nxt = (s2 != prev) ? DEB_W'(1) : cnt + 1'b1;
    accept = (s2 != code) && (nxt == DEB_W'(DEB_CYCLES));
  end

  assign cand = s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      code <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      prev <= s2;
      code <= accept ? s2 : code;
      cnt <= (s2 == code || accept) ? '0 : nxt;
    end
  end
endmodule

// File: rtl/hall_sensor_conditioner.sv
// hall_sensor_conditioner: debounced hall code plus sector, direction, skip, error, period and stall
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        hall_sensor_conditioner_if.slave (raw hall inputs in, conditioned outputs out)
// Parameters:
//   DEB_CYCLES    consecutive identical samples needed to accept a code (>= 2)
//   DEB_W         debounce counter width, must hold DEB_CYCLES
//   PER_W         period counter width, must equal the interface PER_W
//   STALL_CYCLES  cycles without an accepted edge before stall (< 2**PER_W)
module hall_sensor_conditioner import hall_pkg::*; #(
  parameter int DEB_CYCLES = 8,
  parameter int DEB_W = 4,
  parameter int PER_W = 20,
  parameter int STALL_CYCLES = 1000000
) (
  input logic clk,
  input logic rst,
  hall_sensor_conditioner_if.slave bus
);
  logic [HALL_W-1:0] code, cand;
  logic accept;
  logic [SECTOR_W-1:0] sector, new_sec;
  logic sector_ok, edge_pulse, dir, skip, hall_err, period_valid, stall, ref_ok;
  logic legal, restart, step_fwd, step_rev;
  logic [PER_W-1:0] cnt, cnt_inc, period;

  hall_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W(DEB_W)
  ) u_deb (
    .clk(clk),
    .rst(rst),
    .raw({bus.h3_in, bus.h2_in, bus.h1_in}),
    .code(code),
    .cand(cand),
    .accept(accept)
  );

  // A legal code arriving with no trusted previous sector (after reset, an illegal code or a stall)
  // only re-seeds the sector; it never produces a direction or period.
  always_comb begin
    new_sec = hall_decode(cand);
    legal = new_sec != SECTOR_NONE;
    restart = !sector_ok || hall_err || stall;
    step_fwd = new_sec == sector_fwd(sector);
    step_rev = sector == sector_fwd(new_sec);
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  // ref_ok marks that the last edge was an adjacent step, so the next adjacent step closes a
  // period bounded by two genuine commutation edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sector <= '0;
      sector_ok <= 1'b0;
      edge_pulse <= 1'b0;
      dir <= 1'b0;
      skip <= 1'b0;
      hall_err <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
      stall <= 1'b0;
      ref_ok <= 1'b0;
      cnt <= '0;
    end else begin
      edge_pulse <= accept;
      skip <= 1'b0;
      cnt <= cnt_inc;
      if (cnt_inc >= PER_W'(STALL_CYCLES)) begin
        stall <= 1'b1;
        period_valid <= 1'b0;
      end
      if (accept && !legal) begin
        hall_err <= 1'b1;
        period_valid <= 1'b0;
        ref_ok <= 1'b0;
      end else if (accept) begin
        hall_err <= 1'b0;
        sector_ok <= 1'b1;
        sector <= new_sec;
        stall <= 1'b0;
        cnt <= '0;
        if (restart) begin
          period_valid <= 1'b0;
          ref_ok <= 1'b0;
        end else if (step_fwd || step_rev) begin
          dir <= step_fwd;
          period <= cnt_inc;
          period_valid <= ref_ok;
          ref_ok <= 1'b1;
        end else begin
          skip <= 1'b1;
          period_valid <= 1'b0;
          ref_ok <= 1'b0;
        end
      end
    end
  end

  assign {bus.h3, bus.h2, bus.h1} = code;
  assign bus.sector = sector;
  assign bus.sector_ok = sector_ok;
  assign bus.edge_pulse = edge_pulse;
  assign bus.dir = dir;
  assign bus.skip = skip;
  assign bus.hall_err = hall_err;
  assign bus.period = period;
  assign bus.period_valid = period_valid;
  assign bus.stall = stall;
endmodule
